// File: rtl/adder_reg_bank_pkg.sv
// Shared register map, bit positions and engine state encoding for adder_reg_bank.
package adder_reg_bank_pkg;

  localparam logic [4:0] ADDR_CTRL   = 5'h00;
  localparam logic [4:0] ADDR_STATUS = 5'h04;
  localparam logic [4:0] ADDR_OP_A   = 5'h08;
  localparam logic [4:0] ADDR_OP_B   = 5'h0C;
  localparam logic [4:0] ADDR_RESULT = 5'h10;

  localparam int CTRL_START_BIT   = 0;
  localparam int CTRL_IRQ_EN_BIT  = 1;
  localparam int STATUS_BUSY_BIT  = 0;
  localparam int STATUS_DONE_BIT  = 1;
  localparam int STATUS_CARRY_BIT = 2;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    ADD  = 2'd2,
    DONE = 2'd3
  } ENGINE_STATE_E;

  typedef enum logic [2:0] {
    REG_CTRL   = 3'd0,
    REG_STATUS = 3'd1,
    REG_OP_A   = 3'd2,
    REG_OP_B   = 3'd3,
    REG_RESULT = 3'd4,
    REG_NONE   = 3'd7
  } reg_sel_e;

  // word_idx is addr[4:2]; in_range is false when any bit above bit 4 is set
  function automatic reg_sel_e decode_addr(input logic in_range, input logic [2:0] word_idx);
    reg_sel_e sel;
    sel = REG_NONE;
    if (in_range) begin
      case (word_idx)
        ADDR_CTRL[4:2]:   sel = REG_CTRL;
        ADDR_STATUS[4:2]: sel = REG_STATUS;
        ADDR_OP_A[4:2]:   sel = REG_OP_A;
        ADDR_OP_B[4:2]:   sel = REG_OP_B;
        ADDR_RESULT[4:2]: sel = REG_RESULT;
        default:          sel = REG_NONE;
      endcase
    end
    return sel;
  endfunction

endpackage

// File: rtl/adder_reg_bank_core.sv
// Serial adder engine: adds op_a + op_b one CHUNK_W slice per cycle after a start pulse.
//
//   state | meaning
//   IDLE  | waiting for start
//   LOAD  | latch operands, clear chunk index and carry
//   ADD   | add one slice per cycle, ripple carry between slices
//   DONE  | commit result/carry, pulse done, return to IDLE
module adder_serial_core
  import adder_reg_bank_pkg::*;
#(
  parameter int DATA_W  = 32,
  parameter int CHUNK_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [DATA_W-1:0] op_a,
  input  logic [DATA_W-1:0] op_b,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] result,
  output logic              carry
);

  localparam int N_CHUNK = DATA_W / CHUNK_W;
  localparam int IDX_W   = (N_CHUNK > 1) ? $clog2(N_CHUNK) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_CHUNK - 1);

  ENGINE_STATE_E state, state_nxt;

  logic [DATA_W-1:0] work_a;
  logic [DATA_W-1:0] work_b;
  logic [DATA_W-1:0] acc;
  logic              carry_w;
  logic [IDX_W-1:0]  idx;
  logic [CHUNK_W:0]  slice_sum;

  assign slice_sum = {1'b0, work_a[int'(idx)*CHUNK_W +: CHUNK_W]}
                   + {1'b0, work_b[int'(idx)*CHUNK_W +: CHUNK_W]}
                   + {{CHUNK_W{1'b0}}, carry_w};

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = LOAD;
      LOAD:    state_nxt = ADD;
      ADD:     if (idx == LAST_IDX) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      work_a  <= '0;
      work_b  <= '0;
      acc     <= '0;
      carry_w <= 1'b0;
      idx     <= '0;
      result  <= '0;
      carry   <= 1'b0;
    end else begin
      state <= state_nxt;
      case (state)
        LOAD: begin
          work_a  <= op_a;
          work_b  <= op_b;
          acc     <= '0;
          carry_w <= 1'b0;
          idx     <= '0;
        end
        ADD: begin
          acc[int'(idx)*CHUNK_W +: CHUNK_W] <= slice_sum[CHUNK_W-1:0];
          carry_w <= slice_sum[CHUNK_W];
          idx     <= idx + IDX_W'(1);
        end
        DONE: begin
          result <= acc;
          carry  <= carry_w;
        end
        default: ;
      endcase
    end
  end

  assign busy = (state != IDLE);
  assign done = (state == DONE);

endmodule

// File: rtl/adder_reg_bank.sv
// Register bank in front of the serial adder engine: decode, byte strobes, read mux, sticky flags.
// Optional macro ADDER_REG_BANK_IRQ_EN adds o_irq, CTRL.IRQ_EN and W1C on STATUS.DONE.
module adder_reg_bank
  import adder_reg_bank_pkg::*;
#(
  parameter int DATA_W  = 32,
  parameter int CHUNK_W = 8,
  parameter int ADDR_W  = 32
) (
  input  logic                S_AXI_ACLK,
  input  logic                S_AXI_ARESET,
  input  logic                i_en_amba_write,
  input  logic [ADDR_W-1:0]   i_addr_wc,
  input  logic [DATA_W-1:0]   i_data_wc,
  input  logic [DATA_W/8-1:0] i_strb,
  input  logic [ADDR_W-1:0]   i_addr_rc,
  output logic [DATA_W-1:0]   o_data_rc,
  output logic                o_is_busy
`ifdef ADDER_REG_BANK_IRQ_EN
  ,
  output logic                o_irq
`endif
);

  localparam int STRB_W = DATA_W / 8;

  reg_sel_e wr_sel;
  reg_sel_e rd_sel;

  logic [DATA_W-1:0] op_a;
  logic [DATA_W-1:0] op_b;
  logic [DATA_W-1:0] result;
  logic              carry;
  logic              done_flag;
  logic              core_busy;
  logic              core_done;
  logic              wr_en;
  logic              start;
  logic              unused_addr_bits;

  assign wr_sel = decode_addr(i_addr_wc[ADDR_W-1:5] == '0, i_addr_wc[4:2]);
  assign rd_sel = decode_addr(i_addr_rc[ADDR_W-1:5] == '0, i_addr_rc[4:2]);

  // The bank is frozen while the engine runs; the slave reports SLVERR from o_is_busy.
  assign wr_en = i_en_amba_write && !core_busy;
  assign start = wr_en && (wr_sel == REG_CTRL) && i_strb[0] && i_data_wc[CTRL_START_BIT];

  assign unused_addr_bits = ^{i_addr_wc[1:0], i_addr_rc[1:0]};

  always_ff @(posedge S_AXI_ACLK) begin
    if (S_AXI_ARESET) begin
      op_a <= '0;
      op_b <= '0;
    end else if (wr_en) begin
      for (int k = 0; k < STRB_W; k++) begin
        if (i_strb[k]) begin
          if (wr_sel == REG_OP_A) op_a[8*k +: 8] <= i_data_wc[8*k +: 8];
          if (wr_sel == REG_OP_B) op_b[8*k +: 8] <= i_data_wc[8*k +: 8];
        end
      end
    end
  end

`ifdef ADDER_REG_BANK_IRQ_EN
  logic irq_en;
  logic clear_done;

  assign clear_done = wr_en && (wr_sel == REG_STATUS) && i_strb[0] && i_data_wc[STATUS_DONE_BIT];

  always_ff @(posedge S_AXI_ACLK) begin
    if (S_AXI_ARESET) begin
      irq_en <= 1'b0;
      o_irq  <= 1'b0;
    end else begin
      if (wr_en && (wr_sel == REG_CTRL) && i_strb[0]) irq_en <= i_data_wc[CTRL_IRQ_EN_BIT];
      o_irq <= done_flag & irq_en;
    end
  end
`else
  logic clear_done;
  assign clear_done = 1'b0;
`endif

  always_ff @(posedge S_AXI_ACLK) begin
    if (S_AXI_ARESET)    done_flag <= 1'b0;
    else if (start)      done_flag <= 1'b0;
    else if (core_done)  done_flag <= 1'b1;
    else if (clear_done) done_flag <= 1'b0;
  end

  adder_serial_core #(
    .DATA_W  (DATA_W),
    .CHUNK_W (CHUNK_W)
  ) u_core (
    .clk    (S_AXI_ACLK),
    .rst    (S_AXI_ARESET),
    .start  (start),
    .op_a   (op_a),
    .op_b   (op_b),
    .busy   (core_busy),
    .done   (core_done),
    .result (result),
    .carry  (carry)
  );

  always_comb begin
    o_data_rc = '0;
    case (rd_sel)
`ifdef ADDER_REG_BANK_IRQ_EN
      REG_CTRL:   o_data_rc = DATA_W'({irq_en, 1'b0});
`else
      REG_CTRL:   o_data_rc = '0;
`endif
      REG_STATUS: o_data_rc = DATA_W'({carry, done_flag, core_busy});
      REG_OP_A:   o_data_rc = op_a;
      REG_OP_B:   o_data_rc = op_b;
      REG_RESULT: o_data_rc = result;
      default:    o_data_rc = '0;
    endcase
  end

  assign o_is_busy = core_busy;

endmodule

// File: tb/tb_adder_reg_bank.sv
// Scoreboard bench for adder_reg_bank: stimulus pushes expectations, a negedge monitor compares.
module tb_adder_reg_bank;

  logic        clk;
  logic        rst;
  logic        en;
  logic [31:0] addr_wc;
  logic [31:0] data_wc;
  logic [3:0]  strb;
  logic [31:0] addr_rc;
  logic [31:0] data_rc;
  logic        busy;
`ifdef ADDER_REG_BANK_IRQ_EN
  logic        irq;
`endif

  adder_reg_bank dut (
    .S_AXI_ACLK      (clk),
    .S_AXI_ARESET    (rst),
    .i_en_amba_write (en),
    .i_addr_wc       (addr_wc),
    .i_data_wc       (data_wc),
    .i_strb          (strb),
    .i_addr_rc       (addr_rc),
    .o_data_rc       (data_rc),
    .o_is_busy       (busy)
`ifdef ADDER_REG_BANK_IRQ_EN
    ,
    .o_irq           (irq)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] exp_data;
    logic        exp_busy;
    int          exp_irq;
    string       name;
  } exp_t;

  exp_t exp_q[$];
  logic chk_req;
  int   total;
  int   bad;

  always @(negedge clk) begin
    if (chk_req) begin
      exp_t e;
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL scoreboard_empty: monitor had nothing to compare");
      end else begin
        e = exp_q.pop_front();
        total++;
        if (data_rc !== e.exp_data) begin
          bad++;
          $display("FAIL %s data: got 0x%08h want 0x%08h", e.name, data_rc, e.exp_data);
        end
        total++;
        if (busy !== e.exp_busy) begin
          bad++;
          $display("FAIL %s busy: got %0b want %0b", e.name, busy, e.exp_busy);
        end
`ifdef ADDER_REG_BANK_IRQ_EN
        if (e.exp_irq >= 0) begin
          total++;
          if (irq !== e.exp_irq[0]) begin
            bad++;
            $display("FAIL %s irq: got %0b want %0b", e.name, irq, e.exp_irq[0]);
          end
        end
`endif
      end
    end
  end

  // One clock cycle: optionally drive a write, always read ra and queue the expectation.
  task automatic tick(input bit we, input logic [31:0] wa, input logic [31:0] wd,
                      input logic [3:0] ws, input logic [31:0] ra, input logic [31:0] ed,
                      input logic eb, input string nm, input int ei = 0);
    exp_t e;
    en      = we;
    addr_wc = wa;
    data_wc = wd;
    strb    = ws;
    addr_rc = ra;
    e.exp_data = ed;
    e.exp_busy = eb;
    e.exp_irq  = ei;
    e.name     = nm;
    exp_q.push_back(e);
    chk_req = 1'b1;
    @(posedge clk);
    #1;
    en      = 1'b0;
    chk_req = 1'b0;
  endtask

  task automatic rd(input logic [31:0] ra, input logic [31:0] ed, input logic eb,
                    input string nm, input int ei = 0);
    tick(1'b0, 32'h0, 32'h0, 4'h0, ra, ed, eb, nm, ei);
  endtask

  task automatic wr(input logic [31:0] wa, input logic [31:0] wd, input logic [3:0] ws);
    en      = 1'b1;
    addr_wc = wa;
    data_wc = wd;
    strb    = ws;
    @(posedge clk);
    #1;
    en = 1'b0;
  endtask

  initial begin
    total   = 0;
    bad     = 0;
    chk_req = 1'b0;
    rst     = 1'b1;
    en      = 1'b0;
    addr_wc = '0;
    data_wc = '0;
    strb    = '0;
    addr_rc = '0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;

    // reset state
    rd(32'h00, 32'h0, 1'b0, "rst_ctrl");
    rd(32'h04, 32'h0, 1'b0, "rst_status");
    rd(32'h08, 32'h0, 1'b0, "rst_op_a");
    rd(32'h0C, 32'h0, 1'b0, "rst_op_b");
    rd(32'h10, 32'h0, 1'b0, "rst_result");
    rd(32'h14, 32'h0, 1'b0, "rst_unmapped");

    // byte strobes and out-of-range decode
    wr(32'h08, 32'hAABBCCDD, 4'b0101);
    rd(32'h08, 32'h00BB00DD, 1'b0, "strb_0101");
    wr(32'h08, 32'h12345678, 4'b1111);
    rd(32'h08, 32'h12345678, 1'b0, "strb_full");
    rd(32'h28, 32'h0, 1'b0, "oor_alias_read");
    rd(32'h1C, 32'h0, 1'b0, "unmapped_1c");
    wr(32'h10, 32'hFFFFFFFF, 4'b1111);
    rd(32'h10, 32'h0, 1'b0, "ro_result_write");
    wr(32'h2C, 32'h00000055, 4'b1111);
    rd(32'h0C, 32'h0, 1'b0, "oor_alias_write");
    wr(32'h00, 32'h1, 4'b1110);
    rd(32'h04, 32'h0, 1'b0, "start_no_strb");

    // overflow: FFFFFFFF + 1
    wr(32'h08, 32'hFFFFFFFF, 4'b1111);
    wr(32'h0C, 32'h00000001, 4'b1111);
    wr(32'h00, 32'h1, 4'b0001);
    for (int i = 0; i < 6; i++) rd(32'h04, 32'h1, 1'b1, "ovf_busy");
    rd(32'h10, 32'h0, 1'b0, "ovf_result");
    rd(32'h04, 32'h6, 1'b0, "ovf_status");
    rd(32'h00, 32'h0, 1'b0, "ctrl_reads_0");

    // writes while busy are ignored
    wr(32'h08, 32'h0F0F0F0F, 4'b1111);
    wr(32'h0C, 32'h01010101, 4'b1111);
    wr(32'h00, 32'h1, 4'b0001);
    tick(1'b1, 32'h08, 32'h0, 4'hF, 32'h04, 32'h5, 1'b1, "busy_wr_opa");
    tick(1'b1, 32'h00, 32'h1, 4'h1, 32'h04, 32'h5, 1'b1, "busy_restart");
    rd(32'h10, 32'h0, 1'b1, "result_held");
    for (int i = 0; i < 3; i++) rd(32'h04, 32'h5, 1'b1, "busy2");
    rd(32'h10, 32'h10101010, 1'b0, "add2_result");
    rd(32'h04, 32'h2, 1'b0, "add2_status");
    rd(32'h08, 32'h0F0F0F0F, 1'b0, "opa_kept");
    rd(32'h04, 32'h2, 1'b0, "no_second_run");

    // synchronous reset in the third busy cycle
    wr(32'h08, 32'h3, 4'b1111);
    wr(32'h0C, 32'h4, 4'b1111);
    wr(32'h00, 32'h1, 4'b0001);
    rd(32'h04, 32'h1, 1'b1, "pre_rst_busy1");
    rd(32'h04, 32'h1, 1'b1, "pre_rst_busy2");
    rst = 1'b1;
    rd(32'h10, 32'h10101010, 1'b1, "pre_rst_busy3");
    rst = 1'b0;
    rd(32'h10, 32'h0, 1'b0, "post_rst_result");
    rd(32'h04, 32'h0, 1'b0, "post_rst_status");
    rd(32'h08, 32'h0, 1'b0, "post_rst_op_a");

    // carry ripples across chunk boundaries
    wr(32'h08, 32'h00FF00FF, 4'b1111);
    wr(32'h0C, 32'h00010001, 4'b1111);
    wr(32'h00, 32'h1, 4'b0001);
    for (int i = 0; i < 6; i++) rd(32'h10, 32'h0, 1'b1, "ripple_busy");
    rd(32'h10, 32'h01000100, 1'b0, "ripple_result");
    rd(32'h04, 32'h2, 1'b0, "ripple_status");

`ifdef ADDER_REG_BANK_IRQ_EN
    tick(1'b1, 32'h04, 32'h2, 4'h1, 32'h04, 32'h2, 1'b0, "w1c_before");
    tick(1'b1, 32'h00, 32'h2, 4'h1, 32'h04, 32'h0, 1'b0, "w1c_after");
    rd(32'h00, 32'h2, 1'b0, "irq_en_rd");
    tick(1'b1, 32'h00, 32'h3, 4'h1, 32'h00, 32'h2, 1'b0, "irq_start");
    for (int i = 0; i < 6; i++) rd(32'h04, 32'h1, 1'b1, "irq_busy");
    rd(32'h04, 32'h2, 1'b0, "irq_done_set", 0);
    tick(1'b1, 32'h04, 32'h2, 4'h1, 32'h04, 32'h2, 1'b0, "irq_high", 1);
    rd(32'h04, 32'h0, 1'b0, "irq_w1c_done", -1);
    rd(32'h04, 32'h0, 1'b0, "irq_low", 0);
`else
    wr(32'h00, 32'h2, 4'b0001);
    rd(32'h00, 32'h0, 1'b0, "ctrl_bit1_rd0");
    wr(32'h04, 32'h2, 4'b0001);
    rd(32'h04, 32'h2, 1'b0, "status_ro");
`endif

    repeat (2) @(posedge clk);
    if (exp_q.size() != 0) begin
      total++;
      bad++;
      $display("FAIL scoreboard_leftover: got %0d pending want 0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
